// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter and icache fetch request with one pending redirect,
// a circular return-address stack for call/return, and a permanent halt.
module pc_fetch_unit #(
    parameter int              PC_W      = 32,
    parameter logic [PC_W-1:0] RESET_PC  = '0,
    parameter int              RAS_DEPTH = 4
) (
    input  logic            CLK,
    input  logic            nRST,
    input  logic            pcWEN,
    input  logic            ihit,
    input  logic            halt,
    input  logic            redir_valid,
    input  logic [PC_W-1:0] redir_target,
    input  logic            redir_call,
    input  logic            redir_ret,
    input  logic [PC_W-1:0] redir_link,
    output logic [PC_W-1:0] iaddr,
    output logic            iREN,
    output logic [PC_W-1:0] npc,
    output logic            pend_valid,
    output logic            ras_empty,
    output logic            halted
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = $clog2(RAS_DEPTH + 1);
    localparam logic [PC_W-1:0] MASK = ~PC_W'(3);

    typedef enum logic [1:0] {FETCH, PENDING, HALTED} state_t;

    state_t          state, state_nx;
    logic            live, adv, acc, use_top, push, pop, swap;
    logic [PW-1:0]   ptr, ptr_top;
    logic [CW-1:0]   cnt;
    logic [PC_W-1:0] ras [RAS_DEPTH];
    logic [PC_W-1:0] ptgt, raw, tgt, pc_nx;

    // A halt in the current cycle suppresses both advancing and redirect acceptance.
    always_comb begin
        live    = state != HALTED && !halt;
        adv     = ihit && pcWEN && live;
        acc     = redir_valid && live;
        ptr_top = ptr - PW'(1);
        use_top = redir_ret && cnt != '0;
        raw     = use_top ? ras[ptr_top] : redir_target;
        tgt     = raw & MASK;
        swap    = acc && redir_call && use_top;
        push    = acc && redir_call && !use_top;
        pop     = acc && use_top && !redir_call;
        pc_nx   = redir_valid ? tgt : state == PENDING ? ptgt : iaddr + PC_W'(4);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= FETCH;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = (halt || state == HALTED) ? HALTED :
                   (redir_valid && !adv)      ? PENDING :
                   adv                        ? FETCH : state;
    end

    always_comb begin
        iREN       = state != HALTED;
        halted     = state == HALTED;
        pend_valid = state == PENDING;
        ras_empty  = cnt == '0;
        npc        = iaddr + PC_W'(4);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            iaddr <= RESET_PC;
            ptgt  <= '0;
            ptr   <= '0;
            cnt   <= '0;
        end else begin
            if (adv) iaddr <= pc_nx;
            if (acc && !adv) ptgt <= tgt;
            if (push) begin
                ptr <= ptr + PW'(1);
                cnt <= (cnt == CW'(RAS_DEPTH)) ? cnt : cnt + CW'(1);
            end else if (pop) begin
                ptr <= ptr_top;
                cnt <= cnt - CW'(1);
            end
        end
    end

    // Stack contents need no reset: the count alone decides what is valid.
    always_ff @(posedge CLK) begin
        if (push)      ras[ptr]     <= redir_link;
        else if (swap) ras[ptr_top] <= redir_link;
    end
endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Parametrised program-counter and fetch-request unit: the successor to the single-register PC. It holds the fetch address and drives the instruction-cache read request. It advances only on an icache hit while enabled, and captures at most one pending redirect that arrives while a fetch is outstanding. It also keeps a circular return-address stack (RAS) for call/return redirects, and halts fetch on command. It sits between the decode/branch-resolution logic and the icache port of the cache control interface.

## Interface
Parameters:
- PC_W, 32, fetch address width in bits (≥ 4)
- RESET_PC, 0, value of iaddr after reset (low 2 bits must be 0)
- RAS_DEPTH, 4, return-address stack entries (power of 2, ≥ 2)

Ports:
- CLK  in  1  clock, rising edge
- nRST  in  1  asynchronous active-low reset
- pcWEN  in  1  advance enable; low = stall, PC held
- ihit  in  1  icache returned the word at iaddr this cycle
- halt  in  1  stop fetching permanently (until reset)
- redir_valid  in  1  redirect request this cycle
- redir_target  in  PC_W  redirect destination (ignored when redir_ret)
- redir_call  in  1  with redir_valid: push redir_link onto RAS
- redir_ret  in  1  with redir_valid: destination = RAS top, pop
- redir_link  in  PC_W  link address pushed on call
- iaddr  out  PC_W  current fetch address (registered)
- iREN  out  1  instruction read request
- npc  out  PC_W  iaddr + 4 (combinational)
- pend_valid  out  1  a redirect is held pending
- ras_empty  out  1  RAS count == 0
- halted  out  1  unit in HALTED state

## Operation
- Clock and reset: one clock, CLK; reset is asynchronous and active-low on nRST. The polarity and synchronicity are fixed.
- States: FETCH, PENDING, HALTED. Reset → FETCH.
- Reset values:
  - iaddr = RESET_PC
  - pend_valid = 0
  - RAS count = 0, pointer = 0
  - halted = 0
  - iREN = 1
- iREN = (state != HALTED). halted = (state == HALTED).
- Advance condition: adv = ihit & pcWEN & state != HALTED.
- Redirect target resolution (tgt):
  - redir_ret with RAS non-empty → RAS top.
  - redir_ret with RAS empty → redir_target (fallback; no pop).
  - Otherwise → redir_target.
  - Low 2 bits of every loaded address are forced to 0.
- Next-PC priority on adv:
  1. current-cycle redir_valid → tgt
  2. pending redirect → stored target
  3. iaddr + 4, modulo 2^PC_W (wraps to 0)
- FETCH:
  - redir_valid & adv → load tgt; stay in FETCH.
  - redir_valid & !adv → store tgt, set pend_valid; go to PENDING.
- PENDING:
  - A new redir_valid overwrites the stored target (youngest wins).
  - On adv → load the applicable target, clear pend_valid; go to FETCH.
- halt (any state, any cycle) → HALTED next edge:
  - Pending redirect discarded; pend_valid = 0.
  - iaddr frozen; the adv/redirect in that cycle is ignored.
  - HALTED is left only by reset.
- RAS updates happen when a redirect is accepted (captured or applied), regardless of adv:
  - Push on redir_call: write redir_link at pointer; pointer+1; count = min(count+1, RAS_DEPTH). When full, the oldest entry is overwritten (circular wrap).
  - Pop on redir_ret, non-empty: pointer−1, count−1.
  - call & ret together: read top as target, overwrite top with redir_link; pointer and count unchanged.
  - No RAS update while HALTED or in a cycle where halt is asserted.

## Timing
- iaddr changes only on the CLK edge following a cycle with adv. Fetch-to-next-address latency is 1 cycle after the hit.
- A redirect presented with adv takes effect at that same edge. A captured redirect takes effect at the edge of the first later adv.
- pend_valid rises at the edge after capture and falls at the edge of the applying adv.
- npc is combinational from iaddr. No outputs depend combinationally on redir_* inputs.
- Reset assertion mid-operation clears state and RAS asynchronously; iaddr = RESET_PC immediately.

## Test plan
- Reset, then ihit=1 and pcWEN=1 for 3 cycles → iaddr 0x0, 0x4, 0x8, 0xC; iREN=1 throughout. With PC_W=8 starting at 0xFC, one adv → iaddr 0x00.
- Stall and pending capture:
  - Stall: ihit=1, pcWEN=0 → iaddr held.
  - Then redir_valid target 0x100 with ihit=0 → pend_valid=1, iaddr unchanged.
  - Second redirect 0x200 → overwrites the pending target.
  - Next adv → iaddr=0x200, pend_valid=0.
- RAS depth and overflow (RAS_DEPTH=4):
  - 5 calls with links 0x10..0x50, then 4 rets on adv → iaddr 0x50, 0x40, 0x30, 0x20; ras_empty=1.
  - A 5th ret with redir_target 0x999 → iaddr 0x998 (fallback, low bits cleared).
- Simultaneous call+ret, RAS top 0x40 → iaddr=0x40; top now holds redir_link; count unchanged.
- halt asserted together with redir_valid and adv → iaddr unchanged; halted=1, iREN=0, pend_valid=0 next cycle; later ihit/redirects ignored.
- Asynchronous reset pulse mid-PENDING with a non-empty RAS → iaddr=RESET_PC, pend_valid=0, ras_empty=1, iREN=1, with no clock edge required.
